// File: rtl/fetch_align_buffer_pkg.sv
// Shared constants for the fetch alignment buffer.
// Halfword geometry, FIFO sizing and compressed-instruction detect.
package fetch_align_buffer_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          HW_W       = 16;
    localparam int          FIFO_DEPTH = 4;
    localparam int          PTR_W      = $clog2(FIFO_DEPTH);
    localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0]  C_DETECT   = 2'b11;

    typedef logic [HW_W-1:0] hw_t;

    function automatic logic is_compressed(input hw_t hw);
        return hw[1:0] != C_DETECT;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_halfword_fifo.sv
// Four-entry halfword FIFO with dual-width push and pop.
// Head entry always holds the lowest instruction address.
module halfword_fifo
    import fetch_align_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       push_cnt,
    input  hw_t              push_hw0,
    input  hw_t              push_hw1,
    input  logic [1:0]       pop_cnt,
    output hw_t              head_hw0,
    output hw_t              head_hw1,
    output logic [CNT_W-1:0] count
);

    hw_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr1;
    logic [PTR_W-1:0] wr_ptr1;

    assign rd_ptr1  = rd_ptr + PTR_W'(1);
    assign wr_ptr1  = wr_ptr + PTR_W'(1);
    assign head_hw0 = mem[rd_ptr];
    assign head_hw1 = mem[rd_ptr1];

    // Storage writes: one or two halfwords, lower address first.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= push_hw0;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr1] <= push_hw1;
            end
        end
    end

    // Pointers and occupancy, updated by the net of push and pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        end
    end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch alignment buffer: word fetches in, aligned RV32C/RV32I out.
// Redirect flushes the stream; reset restarts it at RESET_PC.
module fetch_align_buffer #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_Mem_Req,
    output logic [31:0]           o_Mem_Addr,
    input  logic [DATA_WIDTH-1:0] i_Mem_RData,
    input  logic                  i_Redirect,
    input  logic [31:0]           i_Redirect_PC,
    output logic                  o_Inst_Valid,
    input  logic                  i_Inst_Ready,
    output logic [DATA_WIDTH-1:0] o_Inst,
    output logic [31:0]           o_PC,
    output logic                  o_is_C_inst
);

    import fetch_align_buffer_pkg::*;

    localparam logic [31:0] RST_FETCH = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] RST_PC    = {RESET_PC[31:1], 1'b0};

    logic [31:0]      fetch_q;
    logic [31:0]      pc_q;
    logic             in_flight;
    logic             skip_lo;

    logic [CNT_W-1:0] occ;
    hw_t              hw0;
    hw_t              hw1;
    logic             head_c;

    logic             resp_valid;
    logic [1:0]       push_cnt;
    hw_t              push_hw0;
    hw_t              push_hw1;

    logic             inst_valid;
    logic             fire;
    logic [1:0]       pop_cnt;
    logic [3:0]       occ_next;
    logic             mem_req;
    logic             unused_redirect_bit0;

    assign unused_redirect_bit0 = i_Redirect_PC[0];

    halfword_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (i_Redirect),
        .push_cnt (push_cnt),
        .push_hw0 (push_hw0),
        .push_hw1 (push_hw1),
        .pop_cnt  (pop_cnt),
        .head_hw0 (hw0),
        .head_hw1 (hw1),
        .count    (occ)
    );

    // Response side: a returning word lands one cycle after its request.
    always_comb begin
        resp_valid = in_flight && !rst && !i_Redirect;
        push_cnt   = 2'd0;
        push_hw0   = i_Mem_RData[15:0];
        push_hw1   = i_Mem_RData[31:16];
        if (resp_valid) begin
            if (skip_lo) begin
                push_cnt = 2'd1;
                push_hw0 = i_Mem_RData[31:16];
            end else begin
                push_cnt = 2'd2;
            end
        end
    end

    // Consumer side: present the head once a whole instruction is buffered.
    always_comb begin
        head_c     = is_compressed(hw0);
        inst_valid = !rst &&
                     (((occ >= CNT_W'(1)) && head_c) ||
                      (occ >= CNT_W'(2)));
        fire       = inst_valid && i_Inst_Ready && !i_Redirect;
        pop_cnt    = 2'd0;
        if (fire) begin
            pop_cnt = head_c ? 2'd1 : 2'd2;
        end
    end

    // Request throttle: only fetch if the next response is sure to fit.
    always_comb begin
        occ_next = 4'(occ) + 4'(push_cnt) - 4'(pop_cnt);
        mem_req  = !rst && !i_Redirect && (occ_next <= 4'd2);
    end

    // Fetch address and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q   <= RST_FETCH;
            in_flight <= 1'b0;
        end else if (i_Redirect) begin
            fetch_q   <= {i_Redirect_PC[31:2], 2'b00};
            in_flight <= 1'b0;
        end else begin
            in_flight <= mem_req;
            if (mem_req) begin
                fetch_q <= fetch_q + 32'd4;
            end
        end
    end

    // Low-half skip for the first word after a mid-word redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_lo <= 1'b0;
        end else if (i_Redirect) begin
            skip_lo <= i_Redirect_PC[1];
        end else if (resp_valid) begin
            skip_lo <= 1'b0;
        end
    end

    // Program counter of the head instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_PC;
        end else if (i_Redirect) begin
            pc_q <= {i_Redirect_PC[31:1], 1'b0};
        end else if (fire) begin
            pc_q <= pc_q + (head_c ? 32'd2 : 32'd4);
        end
    end

    assign o_Mem_Req    = mem_req;
    assign o_Mem_Addr   = rst ? RST_FETCH : {fetch_q[31:2], 2'b00};
    assign o_Inst_Valid = inst_valid;
    assign o_PC         = pc_q;
    assign o_is_C_inst  = head_c;
    assign o_Inst       = head_c ? DATA_WIDTH'({{HW_W{1'b0}}, hw0})
                                 : DATA_WIDTH'({hw1, hw0});

endmodule

// File: doc/fetch_align_buffer.md
FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and memory word width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port o_Mem_Req, output, 1: instruction-memory read request this cycle.
REQ-006 Port o_Mem_Addr, output, 32: word-aligned read address; bits [1:0] are always 0.
REQ-007 Port i_Mem_RData, input, 32: read data returned exactly one cycle after the request.
REQ-008 Port i_Redirect, input, 1: redirect fetch stream (jump or taken branch).
REQ-009 Port i_Redirect_PC, input, 32: redirect target; halfword-aligned, bit 0 ignored.
REQ-010 Port o_Inst_Valid, output, 1: o_Inst, o_PC and o_is_C_inst are valid.
REQ-011 Port i_Inst_Ready, input, 1: consumer (IF/IFID) accepts the instruction this cycle.
REQ-012 Port o_Inst, output, 32: aligned instruction; a compressed instruction is zero-extended to {16'h0, hw}.
REQ-013 Port o_PC, output, 32: address of o_Inst.
REQ-014 Port o_is_C_inst, output, 1: o_Inst is a 16-bit compressed instruction.

Function
REQ-015 Storage is a 4-entry halfword FIFO with an occupancy count of 0..4; the entry at the head has the lowest address.
REQ-016 The head halfword is compressed iff its bits [1:0] != 2'b11.
REQ-017 o_Inst_Valid = (occupancy >= 1 and head compressed) or (occupancy >= 2); output is combinational from the FIFO head, so latency is zero from the FIFO.
REQ-018 A handshake (o_Inst_Valid and i_Inst_Ready) pops 1 halfword (compressed) or 2 halfwords (otherwise) and advances o_PC by 2 or 4 respectively.
REQ-019 A 32-bit instruction is output as {entry1, entry0}, with entry0 the head.
REQ-020 o_Mem_Req is asserted when not in reset, i_Redirect is low, and the next-cycle occupancy (current occupancy + this cycle's push - this cycle's pop) is <= 2; the FIFO never overflows.
REQ-021 On a request, o_Mem_Addr = fetch address; the fetch address then advances by 4 with 32-bit wrap-around; one in-flight flag tracks the pending response.
REQ-022 A response pushes two halfwords, low half first, except the first response after a redirect to a PC with bit 1 set, which pushes only the upper half.
REQ-023 A push and a pop in the same cycle are both applied, and the occupancy update is net.
REQ-024 When i_Redirect is high, it has priority over everything else in that cycle: the FIFO is flushed, the in-flight response (if any) is discarded, o_PC <= i_Redirect_PC & ~1, fetch address <= i_Redirect_PC & ~3, the skip-low-half flag <= i_Redirect_PC[1], and no handshake pop is counted that cycle.
REQ-025 While i_Inst_Ready is low, the FIFO holds and o_Inst, o_PC and o_is_C_inst remain stable.
REQ-026 A 32-bit instruction whose upper half is not yet buffered (occupancy == 1 and head not compressed) is not presented; o_Inst_Valid stays low until the second halfword arrives.

Reset
REQ-027 While rst is high at a clock edge: occupancy = 0, in-flight = 0, skip flag = 0, fetch address = RESET_PC, o_PC = RESET_PC.
REQ-028 While rst is high: o_Mem_Req = 0, o_Inst_Valid = 0, and o_Mem_Addr = RESET_PC.
REQ-029 A response arriving in the cycle after reset asserts is discarded; reset overrides a simultaneous redirect.

Structure
REQ-030 The shared package holds RESET_PC, the halfword width (16), the FIFO depth (4), and the compressed-detect constant 2'b11.
REQ-031 One sub-module, halfword_fifo, contains the 4-entry storage, the pointers and the occupancy; the push-1/push-2 and pop-1/pop-2 control stays in fetch_align_buffer.

Verification
REQ-032 Scenario: after reset, memory returns 32'h0013_0093 at address 0 and i_Inst_Ready = 1. Required: the first request is to address 0; the response is output as a 32-bit instruction with o_PC = 0 and o_is_C_inst = 0.
REQ-033 Scenario: memory word 32'h4505_0505. Required: two compressed outputs, 32'h0000_0505 at PC 0 then 32'h0000_4505 at PC 2.
REQ-034 Scenario: word at 0 is 32'h0093_0505 and word at 4 is 32'hxxxx_0013. Required: compressed output at PC 0, then the straddling 32-bit instruction 32'h0013_0093 at PC 2.
REQ-035 Scenario: redirect to 32'h0000_0102 with a response in flight. Required: the in-flight data is dropped; the next request is to 32'h100; only the upper half is pushed; the first o_PC is 32'h102.
REQ-036 Scenario: i_Inst_Ready held low for 10 cycles. Required: occupancy stops at 4, o_Mem_Req deasserts, and no data is lost or reordered after ready returns.
REQ-037 Scenario: rst pulsed mid-stream with a request outstanding. Required: o_Inst_Valid = 0 in the next cycle and fetching restarts at RESET_PC.
